// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic: Goldilocks constants and canonical modular helpers,
// used by both the forward and inverse butterflies.
package ntt_pkg;
    localparam int COEFF_W = 64;
    localparam logic [COEFF_W-1:0] MODULUS = 64'hFFFFFFFF00000001;
    localparam logic [COEFF_W-1:0] INV2    = 64'h7FFFFFFF80000001;

    typedef logic [COEFF_W-1:0] coeff_t;

    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b, input coeff_t m);
        logic [COEFF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[COEFF_W-1:0];
    endfunction

    function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b, input coeff_t m);
        return (a >= b) ? a - b : a - b + m;
    endfunction

    // x * 2^-1 mod m for odd m: an odd x is made even by adding m first.
    function automatic coeff_t mod_half(input coeff_t x, input coeff_t m);
        logic [COEFF_W:0] s;
        s = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
        return coeff_t'(s >> 1);
    endfunction
endpackage

// File: rtl/goldilocks_mulred.sv
// Two-stage (a*b) mod M with optional halving of the result; a shift/add
// reduction is used for the Goldilocks prime, a generic modulo otherwise.
module goldilocks_mulred #(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(ntt_pkg::MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             half,
    output logic [WIDTH-1:0] y
);
    import ntt_pkg::*;

    localparam bit GOLD = (WIDTH == COEFF_W) && (MODULUS == ntt_pkg::MODULUS);

    logic [2*WIDTH-1:0] prod;
    logic               prod_half;
    logic [WIDTH-1:0]   red;

    generate
        if (GOLD) begin : g_gold
            // 2^64 = 2^32-1 and 2^96 = -1 (mod M): prod = lo + hl*(2^32-1) - hh.
            coeff_t lo, lo_c, hh, t;
            assign lo   = coeff_t'(prod[WIDTH-1:0]);
            assign lo_c = (lo >= coeff_t'(MODULUS)) ? lo - coeff_t'(MODULUS) : lo;
            assign hh   = coeff_t'(prod[2*WIDTH-1:WIDTH+32]);
            assign t    = {prod[WIDTH+31:WIDTH], 32'h0} - coeff_t'(prod[WIDTH+31:WIDTH]);
            assign red  = WIDTH'(mod_add(mod_sub(lo_c, hh, coeff_t'(MODULUS)), t,
                                         coeff_t'(MODULUS)));
        end else begin : g_generic
            assign red = WIDTH'(prod % (2*WIDTH)'(MODULUS));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prod      <= '0;
            prod_half <= 1'b0;
            y         <= '0;
        end else if (en) begin
            prod      <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
            prod_half <= half;
            y         <= prod_half ? WIDTH'(mod_half(coeff_t'(red), coeff_t'(MODULUS))) : red;
        end
    end
endmodule

// File: rtl/intt_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly, 3 stages:
// out_a = (a+b)[/2] mod M, out_b = (a-b)*w[/2] mod M, tag passed through.
module intt_butterfly #(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(ntt_pkg::MODULUS),
    parameter int               TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_half,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [TAG_W-1:0] out_tag
);
    import ntt_pkg::*;

    localparam int     STAGES = 3;
    localparam coeff_t M      = coeff_t'(MODULUS);

    logic              adv;
    logic              accept;
    logic [STAGES:1]   vld_pipe;
    logic [WIDTH-1:0]  s1_sum, s1_diff, s1_w, s2_sum;
    logic              s1_half, s2_half;
    logic [TAG_W-1:0]  s1_tag, s2_tag;

    // Single global enable: the whole pipe freezes while the output is stalled.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            out_a    <= '0;
            out_tag  <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            out_a    <= s2_half ? WIDTH'(mod_half(coeff_t'(s2_sum), M)) : s2_sum;
            out_tag  <= s2_tag;
        end
    end

    // Datapath registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sum  <= WIDTH'(mod_add(coeff_t'(in_a), coeff_t'(in_b), M));
            s1_diff <= WIDTH'(mod_sub(coeff_t'(in_a), coeff_t'(in_b), M));
            s1_w    <= in_w;
            s1_half <= in_half;
            s1_tag  <= in_tag;
            s2_sum  <= s1_sum;
            s2_half <= s1_half;
            s2_tag  <= s1_tag;
        end
    end

    goldilocks_mulred #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mulred (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .a    (s1_diff),
        .b    (s1_w),
        .half (s1_half),
        .y    (out_b)
    );
endmodule

// File: tb/tb_intt_butterfly.sv
// Self-checking bench for intt_butterfly: directed vector table, random
// backpressure stream against a modular-arithmetic model, mid-stream reset.
module tb_intt_butterfly;
    localparam logic [63:0]  M   = 64'hFFFFFFFF00000001;
    localparam logic [127:0] MW  = {64'h0, M};
    localparam logic [127:0] HLF = (MW + 128'd1) / 128'd2;

    typedef struct {
        logic [63:0] a, b, w;
        logic        half;
        logic [7:0]  tag;
        logic [63:0] ea, eb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_half, out_valid, out_ready;
    logic [63:0] in_a, in_b, in_w, out_a, out_b;
    logic [7:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    vec_t        tbl[10];
    logic [63:0] qa[$], qb[$];
    logic [7:0]  qt[$];

    always #5 clk = ~clk;

    intt_butterfly dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_half(in_half), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic; halving is multiplication by (M+1)/2.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [63:0] w,
                         input logic h, output logic [63:0] ea, output logic [63:0] eb);
        logic [127:0] f, s, d;
        f  = h ? HLF : 128'd1;
        s  = ({64'h0, a} + {64'h0, b}) % MW;
        s  = (s * f) % MW;
        d  = ({64'h0, a} + MW - {64'h0, b}) % MW;
        d  = (d * {64'h0, w}) % MW;
        d  = (d * f) % MW;
        ea = s[63:0];
        eb = d[63:0];
    endtask

    function automatic logic [63:0] rnd();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       x = 64'h0;
            1:       x = M - 64'd1;
            default: x = x % M;
        endcase
        return x;
    endfunction

    task automatic drive(input vec_t v);
        in_a = v.a; in_b = v.b; in_w = v.w; in_half = v.half; in_tag = v.tag;
    endtask

    // One isolated beat: checks exact 3-cycle latency and the result.
    task automatic send_dir(input vec_t v);
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk("dir_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat3_valid", 64'(out_valid), 64'd1);
        chk("dir_out_a", out_a, v.ea);
        chk("dir_out_b", out_b, v.eb);
        chk("dir_out_tag", 64'(out_tag), 64'(v.tag));
    endtask

    initial begin
        tbl[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 8'h11, 64'd8, 64'd4};
        tbl[1] = '{M - 64'd1, 64'd2, 64'd1, 1'b0, 8'h12, 64'd1, M - 64'd3};
        tbl[2] = '{64'd1, 64'd3, 64'd1, 1'b0, 8'h13, 64'd4, 64'hFFFFFFFEFFFFFFFF};
        tbl[3] = '{64'h100000000, 64'd0, 64'h100000000, 1'b0, 8'h14, 64'h100000000, 64'hFFFFFFFF};
        tbl[4] = '{64'd3, 64'd0, 64'd1, 1'b1, 8'h15, 64'h7FFFFFFF80000002, 64'h7FFFFFFF80000002};
        tbl[5] = '{64'd6, 64'd2, 64'd3, 1'b1, 8'h16, 64'd4, 64'd6};
        tbl[6] = '{64'd7, 64'd7, 64'd12345, 1'b0, 8'h17, 64'd14, 64'd0};
        tbl[7] = '{M - 64'd5, 64'd5, 64'd9, 1'b0, 8'h18, 64'd0, M - 64'd90};
        tbl[8] = '{64'd0, 64'd1, M - 64'd1, 1'b0, 8'h19, 64'd1, 64'd1};
        tbl[9] = '{64'd1, 64'd0, 64'd1, 1'b1, 8'h1A, 64'h7FFFFFFF80000001, 64'h7FFFFFFF80000001};

        // Reset with a beat offered: nothing accepted, everything cleared.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(tbl[0]);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_out_b", out_b, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end

        for (int i = 0; i < 10; i++) send_dir(tbl[i]);

        // Random back-to-back stream with random backpressure.
        begin
            int          sent, rcvd, cyc;
            logic        stalled;
            logic [63:0] pa, pb, ea, eb;
            logic [7:0]  pt;
            vec_t        v;
            sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
            pa = '0; pb = '0; pt = '0;
            while (rcvd < 16 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (stalled) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_a", out_a, pa);
                    chk("stall_b", out_b, pb);
                    chk("stall_tag", 64'(out_tag), 64'(pt));
                end
                out_ready = ($urandom_range(0, 2) != 0);
                if (sent < 16) begin
                    v.a = rnd(); v.b = rnd(); v.w = rnd();
                    v.half = 1'($urandom_range(0, 1));
                    v.tag = 8'h40 + 8'(sent);
                    drive(v);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                chk("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                if (in_valid && in_ready) begin
                    model(in_a, in_b, in_w, in_half, ea, eb);
                    qa.push_back(ea); qb.push_back(eb); qt.push_back(in_tag);
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (qt.size() == 0) begin
                        chk("bp_unexpected_beat", 64'(out_tag), 64'hFFFF);
                    end else begin
                        chk("bp_out_tag", 64'(out_tag), 64'(qt.pop_front()));
                        chk("bp_out_a", out_a, qa.pop_front());
                        chk("bp_out_b", out_b, qb.pop_front());
                    end
                    rcvd++;
                end
                stalled = out_valid && !out_ready;
                pa = out_a; pb = out_b; pt = out_tag;
            end
            chk("bp_received", 64'(rcvd), 64'd16);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end

        // Drain, then reset with three beats in flight.
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            in_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        drive(tbl[3]);
        #1 chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready2", 64'(in_ready), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
        end
        send_dir(tbl[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
